// File: rtl/vgm_cmd_seq.sv
// VGM command sequencer: decodes YM2610 register writes and waits from a byte
// stream and drives the jt10 CPU write port with registered addr/din/wr_n.
module vgm_cmd_seq #(
    parameter int unsigned WR_LEN = 6,
    parameter int unsigned WR_GAP = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       tick44,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic [1:0] fm_addr,
    output logic [7:0] fm_din,
    output logic       fm_wr_n,
    output logic       playing,
    output logic       done,
    output logic       bad_cmd
);

    typedef enum logic [3:0] {
        S_IDLE, S_OP, S_ARG0, S_ARG1, S_WR1, S_GAP1,
        S_WR2, S_GAP2, S_WAIT, S_END, S_ERR
    } state_t;

    localparam logic [15:0] LEN_M1 = 16'(WR_LEN - 1);
    localparam logic [15:0] GAP_M1 = 16'(WR_GAP - 1);

    state_t      state, state_n;
    logic        port, port_n;
    logic        cmd_wait, cmd_wait_n;
    logic [7:0]  reg_addr, reg_addr_n;
    logic [7:0]  reg_data, reg_data_n;
    logic [15:0] timer, timer_n;
    logic [15:0] wait_cnt, wait_n;
    logic [1:0]  addr_n;
    logic [7:0]  din_n;
    logic        playing_n, done_n, bad_n;
    logic        ready_n, wr_n_n;
    logic        take;

    // byte_ready is a registered copy of "next state accepts bytes", so it is
    // exactly the handshake qualifier for the current state.
    assign take = byte_valid && byte_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can leave a value unassigned (latch).
        state_n    = state;
        port_n     = port;
        cmd_wait_n = cmd_wait;
        reg_addr_n = reg_addr;
        reg_data_n = reg_data;
        timer_n    = timer;
        wait_n     = wait_cnt;
        addr_n     = fm_addr;
        din_n      = fm_din;
        playing_n  = playing;
        done_n     = done;
        bad_n      = bad_cmd;

        case (state)
            S_IDLE, S_END, S_ERR: begin
                if (start) begin
                    state_n   = S_OP;
                    done_n    = 1'b0;
                    bad_n     = 1'b0;
                    playing_n = 1'b1;
                end
            end
            S_OP: begin
                if (take) begin
                    case (byte_data)
                        8'h58, 8'h59: begin
                            port_n     = byte_data[0];
                            cmd_wait_n = 1'b0;
                            state_n    = S_ARG0;
                        end
                        8'h61: begin
                            cmd_wait_n = 1'b1;
                            state_n    = S_ARG0;
                        end
                        8'h62: begin
                            wait_n  = 16'd735;
                            state_n = S_WAIT;
                        end
                        8'h63: begin
                            wait_n  = 16'd882;
                            state_n = S_WAIT;
                        end
                        8'h66: begin
                            done_n    = 1'b1;
                            playing_n = 1'b0;
                            state_n   = S_END;
                        end
                        default: begin
                            if (byte_data[7:4] == 4'h7) begin
                                wait_n  = 16'(byte_data[3:0]) + 16'd1;
                                state_n = S_WAIT;
                            end else begin
                                bad_n     = 1'b1;
                                playing_n = 1'b0;
                                state_n   = S_ERR;
                            end
                        end
                    endcase
                end
            end
            S_ARG0: begin
                if (take) begin
                    reg_addr_n = byte_data;
                    state_n    = S_ARG1;
                end
            end
            S_ARG1: begin
                if (take) begin
                    if (cmd_wait) begin
                        // 0x61 count is little-endian: ARG0 was the low byte.
                        wait_n  = {byte_data, reg_addr};
                        state_n = ({byte_data, reg_addr} == 16'd0) ? S_OP : S_WAIT;
                    end else begin
                        reg_data_n = byte_data;
                        timer_n    = LEN_M1;
                        addr_n     = {port, 1'b0};
                        din_n      = reg_addr;
                        state_n    = S_WR1;
                    end
                end
            end
            S_WR1: begin
                if (timer == 16'd0) begin
                    timer_n = GAP_M1;
                    state_n = S_GAP1;
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            S_GAP1: begin
                if (timer == 16'd0) begin
                    timer_n = LEN_M1;
                    addr_n  = {port, 1'b1};
                    din_n   = reg_data;
                    state_n = S_WR2;
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            S_WR2: begin
                if (timer == 16'd0) begin
                    timer_n = GAP_M1;
                    state_n = S_GAP2;
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            S_GAP2: begin
                if (timer == 16'd0) begin
                    state_n = S_OP;
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            S_WAIT: begin
                if (tick44) begin
                    wait_n = wait_cnt - 16'd1;
                    if (wait_cnt == 16'd1) begin
                        state_n = S_OP;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // stop overrides everything, including a simultaneous start.
        if (stop) begin
            state_n   = S_IDLE;
            playing_n = 1'b0;
        end

        ready_n = (state_n == S_OP) || (state_n == S_ARG0) || (state_n == S_ARG1);
        wr_n_n  = !((state_n == S_WR1) || (state_n == S_WR2));
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state      <= S_IDLE;
            port       <= 1'b0;
            cmd_wait   <= 1'b0;
            reg_addr   <= 8'h00;
            reg_data   <= 8'h00;
            timer      <= 16'd0;
            wait_cnt   <= 16'd0;
            fm_addr    <= 2'b00;
            fm_din     <= 8'h00;
            fm_wr_n    <= 1'b1;
            byte_ready <= 1'b0;
            playing    <= 1'b0;
            done       <= 1'b0;
            bad_cmd    <= 1'b0;
        end else begin
            state      <= state_n;
            port       <= port_n;
            cmd_wait   <= cmd_wait_n;
            reg_addr   <= reg_addr_n;
            reg_data   <= reg_data_n;
            timer      <= timer_n;
            wait_cnt   <= wait_n;
            fm_addr    <= addr_n;
            fm_din     <= din_n;
            fm_wr_n    <= wr_n_n;
            byte_ready <= ready_n;
            playing    <= playing_n;
            done       <= done_n;
            bad_cmd    <= bad_n;
        end
    end

endmodule
